game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Game-level sequencer for the brick-breaker datapath.
- Owns the brick-existence vector, lives, score and serve timing; drives the ball engine's start and per-ball reset.
- Consumes the ball engine's per-brick hit pulses and its ball-lost flag.
- Sits between the key inputs and the ball/brick datapath; outputs also feed the VGA overlay.

Parameters:
- NUM_BRICKS, 6, number of bricks tracked (width of brick vectors).
- LIVES_INIT, 3, lives at game start (1..3).
- SERVE_DELAY, 25000000, clk cycles spent in WAIT before a re-serve (>=1).
- SCORE_W, 8, score width.
- POINTS_PER_BRICK, 1, score increment per brick cleared.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start_btn  in  1  start/serve key, level, already synchronised, active-high
- brick_hit  in  NUM_BRICKS  one-cycle pulse per brick struck by the ball
- ball_lost  in  1  ball engine "destroyed" flag (level)
- ball_start  out  1  start to ball engine; high only in PLAY
- ball_rst_n  out  1  active-low re-serve reset to ball engine; combined externally as rst & ball_rst_n
- bricks_exist  out  NUM_BRICKS  1 = brick present
- lives  out  2  remaining lives
- score  out  SCORE_W  accumulated score
- state  out  3  current FSM state, for debug/overlay
- game_over  out  1  high in OVER
- game_won  out  1  high in WON

Behaviour:
- All outputs registered.
- Reset values: state=IDLE, ball_start=0, ball_rst_n=1, bricks_exist=all ones, lives=LIVES_INIT, score=0, game_over=0, game_won=0.
- press = start_btn & ~start_btn_q (rising edge, one cycle). A held key produces exactly one press.
- States: IDLE=0, SERVE=1, PLAY=2, LOST=3, WAIT=4, OVER=5, WON=6.
- IDLE: load bricks_exist=all ones, lives=LIVES_INIT, score=0, ball_rst_n=0. Next state SERVE unconditionally (one cycle).
- SERVE: ball_rst_n=1, ball_start=0. On press go to PLAY; ball_start is 1 from the first PLAY cycle.
- PLAY:
  - eff = brick_hit & bricks_exist.
  - bricks_exist <= bricks_exist & ~brick_hit.
  - score <= score + popcount(eff)*POINTS_PER_BRICK, saturating at 2^SCORE_W-1.
  - Hits on already-cleared bricks are ignored (no score).
- PLAY exits, in priority order:
  - (bricks_exist & ~brick_hit)==0: go to WON. Takes precedence over a simultaneous ball_lost.
  - ball_lost and lives==1: lives<=0, go to OVER.
  - ball_lost and lives>1: lives<=lives-1, go to LOST.
- LOST: one cycle. ball_rst_n=0, ball_start=0, serve counter cleared. Next state WAIT.
- WAIT:
  - ball_rst_n=1, ball_start=0; counter increments.
  - When counter==SERVE_DELAY-1, go to SERVE; total WAIT dwell is SERVE_DELAY cycles.
  - Presses during WAIT are ignored.
- OVER / WON:
  - ball_start=0; game_over / game_won held high.
  - bricks, lives and score frozen.
  - On press go to IDLE, which reinitialises.
- brick_hit and ball_lost are ignored in every state except PLAY.
- Undefined state encodings go to IDLE.
- Async reset mid-game returns to the reset values immediately, regardless of state or counter value.
- lives never underflows; score never wraps.

Decomposition:
- Package game_pkg holds:
  - the state enum/localparams (IDLE..WON, 3-bit);
  - NUM_BRICKS;
  - ALL_BRICKS = {NUM_BRICKS{1'b1}};
  - the popcount function for NUM_BRICKS-wide vectors.
- Sub-module btn_edge: a registered rising-edge detector for start_btn, with async active-low reset.

Test Plan:
- Reset, press -> state goes IDLE->SERVE->PLAY. In PLAY: ball_start=1, bricks_exist=6'b111111, lives=3, score=0.
- In PLAY, brick_hit=6'b000101 for one cycle, then 6'b000001 again -> bricks_exist=6'b111010, score=2 (repeat hit not scored).
- ball_lost with lives=3 (SERVE_DELAY=4) -> LOST for exactly 1 cycle with ball_rst_n=0, then WAIT for exactly 4 cycles, then SERVE, lives=2. A press during WAIT does nothing.
- lives=1, ball_lost -> OVER with game_over=1 and lives=0. Press -> IDLE then SERVE, with lives=3, score=0, bricks all ones.
- Last remaining brick hit in the same cycle as ball_lost -> WON, game_won=1, lives unchanged, score incremented.
- SCORE_W=2, clear 5 bricks -> score saturates at 3. Async reset asserted mid-WAIT -> all outputs return to reset values at once.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the brick-breaker game sequencer.
package game_pkg;

    localparam int NUM_BRICKS = 6;
    localparam int PC_W       = $clog2(NUM_BRICKS + 1);

    localparam logic [NUM_BRICKS-1:0] ALL_BRICKS = {NUM_BRICKS{1'b1}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        LOST  = 3'd3,
        WAIT  = 3'd4,
        OVER  = 3'd5,
        WON   = 3'd6
    } game_state_e;

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_BRICKS-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_BRICKS; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/game_ctrl_btn_edge.sv
// Rising-edge detector for the already-synchronised start key.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic btn_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
        end
    end

    // One-cycle pulse: a held key yields a single press.
    assign press = btn & ~btn_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-level sequencer: bricks, lives, score and serve timing for the ball engine.
module game_ctrl
    import game_pkg::*;
#(
    parameter int NUM_BRICKS       = game_pkg::NUM_BRICKS,
    parameter int LIVES_INIT       = 3,
    parameter int SERVE_DELAY      = 25000000,
    parameter int SCORE_W          = 8,
    parameter int POINTS_PER_BRICK = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_btn,
    input  logic [NUM_BRICKS-1:0] brick_hit,
    input  logic                  ball_lost,
    output logic                  ball_start,
    output logic                  ball_rst_n,
    output logic [NUM_BRICKS-1:0] bricks_exist,
    output logic [1:0]            lives,
    output logic [SCORE_W-1:0]    score,
    output logic [2:0]            state,
    output logic                  game_over,
    output logic                  game_won
);

    localparam int          CNT_W     = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [31:0] SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;

    game_state_e             state_reg, state_next;
    logic [NUM_BRICKS-1:0]   bricks_reg, bricks_next;
    logic [1:0]              lives_reg, lives_next;
    logic [SCORE_W-1:0]      score_reg, score_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    ball_start_reg, ball_rst_n_reg, game_over_reg, game_won_reg;
    logic                    press;
    logic [NUM_BRICKS-1:0]   eff_hit, remain;
    logic [31:0]             score_sum;

    btn_edge u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (start_btn),
        .press (press)
    );

    assign eff_hit   = brick_hit & bricks_reg;
    assign remain    = bricks_reg & ~brick_hit;
    assign score_sum = 32'(score_reg) + 32'(popcount(eff_hit)) * 32'(POINTS_PER_BRICK);

    always_comb begin
        state_next  = state_reg;
        bricks_next = bricks_reg;
        lives_next  = lives_reg;
        score_next  = score_reg;
        cnt_next    = cnt_reg;

        case (state_reg)
            IDLE: state_next = SERVE;
            SERVE: begin
                if (press) state_next = PLAY;
            end
            PLAY: begin
                bricks_next = remain;
                score_next  = (score_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(score_sum);
                // Clearing the last brick wins even if the ball is lost the same cycle.
                if (remain == '0) begin
                    state_next = WON;
                end else if (ball_lost) begin
                    if (lives_reg <= 2'd1) begin
                        lives_next = 2'd0;
                        state_next = OVER;
                    end else begin
                        lives_next = lives_reg - 2'd1;
                        state_next = LOST;
                    end
                end
            end
            LOST: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = SERVE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            OVER, WON: begin
                if (press) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Reinitialise on every entry into IDLE so the new game starts clean.
        if (state_next == IDLE) begin
            bricks_next = ALL_BRICKS;
            lives_next  = 2'(LIVES_INIT);
            score_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            bricks_reg     <= ALL_BRICKS;
            lives_reg      <= 2'(LIVES_INIT);
            score_reg      <= '0;
            cnt_reg        <= '0;
            ball_start_reg <= 1'b0;
            ball_rst_n_reg <= 1'b1;
            game_over_reg  <= 1'b0;
            game_won_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bricks_reg     <= bricks_next;
            lives_reg      <= lives_next;
            score_reg      <= score_next;
            cnt_reg        <= cnt_next;
            // Decoded from the next state so the flags line up with the state they describe.
            ball_start_reg <= (state_next == PLAY);
            ball_rst_n_reg <= !((state_next == IDLE) || (state_next == LOST));
            game_over_reg  <= (state_next == OVER);
            game_won_reg   <= (state_next == WON);
        end
    end

    assign ball_start   = ball_start_reg;
    assign ball_rst_n   = ball_rst_n_reg;
    assign bricks_exist = bricks_reg;
    assign lives        = lives_reg;
    assign score        = score_reg;
    assign state        = state_reg;
    assign game_over    = game_over_reg;
    assign game_won     = game_won_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed vector table, async-reset case, random vs. model.
module tb_game_ctrl;

    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_LOST = 3, S_WAIT = 4, S_OVER = 5, S_WON = 6;
    localparam int DELAY = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_btn = 1'b0;
    logic [5:0] brick_hit = '0;
    logic       ball_lost = 1'b0;

    logic       ball_start, ball_rst_n, game_over, game_won;
    logic [5:0] bricks_exist;
    logic [1:0] lives;
    logic [7:0] score;
    logic [2:0] state;

    logic       b_ball_start, b_ball_rst_n, b_game_over, b_game_won;
    logic [5:0] b_bricks_exist;
    logic [1:0] b_lives;
    logic [1:0] b_score;
    logic [2:0] b_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    game_ctrl #(.NUM_BRICKS(6), .LIVES_INIT(3), .SERVE_DELAY(DELAY), .SCORE_W(8), .POINTS_PER_BRICK(1)) dut_a (
        .clk(clk), .rst(rst), .start_btn(start_btn), .brick_hit(brick_hit), .ball_lost(ball_lost),
        .ball_start(ball_start), .ball_rst_n(ball_rst_n), .bricks_exist(bricks_exist), .lives(lives),
        .score(score), .state(state), .game_over(game_over), .game_won(game_won)
    );

    // Narrow-score copy driven by the same stimulus to exercise saturation.
    game_ctrl #(.NUM_BRICKS(6), .LIVES_INIT(3), .SERVE_DELAY(DELAY), .SCORE_W(2), .POINTS_PER_BRICK(1)) dut_b (
        .clk(clk), .rst(rst), .start_btn(start_btn), .brick_hit(brick_hit), .ball_lost(ball_lost),
        .ball_start(b_ball_start), .ball_rst_n(b_ball_rst_n), .bricks_exist(b_bricks_exist), .lives(b_lives),
        .score(b_score), .state(b_state), .game_over(b_game_over), .game_won(b_game_won)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    typedef struct {
        logic       btn;
        logic [5:0] hit;
        logic       lost;
        int         st;
        logic [5:0] bricks;
        int         lv;
        int         sc;
        logic       bs;
        logic       rn;
        logic       ov;
        logic       wn;
        logic       vals;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic btn, input logic [5:0] hit, input logic lost, input int st,
                       input logic [5:0] bricks, input int lv, input int sc, input logic bs,
                       input logic rn, input logic ov, input logic wn, input logic vals);
        vec_t v;
        v = '{btn, hit, lost, st, bricks, lv, sc, bs, rn, ov, wn, vals};
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, int'(state), S_IDLE);
        chk({tag, "_bricks"}, int'(bricks_exist), 63);
        chk({tag, "_lives"}, int'(lives), 3);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_bstart"}, int'(ball_start), 0);
        chk({tag, "_brstn"}, int'(ball_rst_n), 1);
        chk({tag, "_over"}, int'(game_over), 0);
        chk({tag, "_won"}, int'(game_won), 0);
        chk({tag, "_b_score"}, int'(b_score), 0);
        chk({tag, "_b_state"}, int'(b_state), S_IDLE);
    endtask

    // Reference model: game rules at the level of "what happens this cycle".
    int         m_state, m_lives, m_score, m_wait_left;
    logic [5:0] m_bricks;
    logic       m_prev_btn;

    task automatic model_init();
        m_state = S_IDLE; m_lives = 3; m_score = 0; m_bricks = 6'h3f;
        m_wait_left = 0; m_prev_btn = 1'b0;
    endtask

    task automatic model_step(input logic btn, input logic [5:0] hit, input logic lost);
        bit press;
        int gained;
        press = btn && !m_prev_btn;
        m_prev_btn = btn;
        case (m_state)
            S_IDLE:  m_state = S_SERVE;
            S_SERVE: if (press) m_state = S_PLAY;
            S_PLAY: begin
                gained = 0;
                for (int i = 0; i < 6; i++) if (hit[i] && m_bricks[i]) gained++;
                m_score += gained;
                m_bricks = m_bricks & ~hit;
                if (m_bricks == 0) m_state = S_WON;
                else if (lost) begin
                    m_lives--;
                    m_state = (m_lives == 0) ? S_OVER : S_LOST;
                end
            end
            S_LOST: begin m_wait_left = DELAY; m_state = S_WAIT; end
            S_WAIT: begin
                m_wait_left--;
                if (m_wait_left == 0) m_state = S_SERVE;
            end
            default: if (press) begin
                m_state = S_IDLE; m_lives = 3; m_score = 0; m_bricks = 6'h3f;
            end
        endcase
    endtask

    initial begin
        // Directed sequence: serve, scoring, repeat hit, lives, game over, restart, win with saturation.
        add(0, 6'h00, 0, S_SERVE, 6'h3f, 3, 0, 0, 1, 0, 0, 1);
        add(1, 6'h00, 0, S_PLAY,  6'h3f, 3, 0, 1, 1, 0, 0, 1);
        add(1, 6'h05, 0, S_PLAY,  6'h3a, 3, 2, 1, 1, 0, 0, 1);
        add(0, 6'h01, 0, S_PLAY,  6'h3a, 3, 2, 1, 1, 0, 0, 1);
        add(0, 6'h00, 1, S_LOST,  6'h3a, 2, 2, 0, 0, 0, 0, 1);
        add(0, 6'h00, 1, S_WAIT,  6'h3a, 2, 2, 0, 1, 0, 0, 1);
        add(1, 6'h00, 0, S_WAIT,  6'h3a, 2, 2, 0, 1, 0, 0, 1);
        add(0, 6'h00, 0, S_WAIT,  6'h3a, 2, 2, 0, 1, 0, 0, 1);
        add(1, 6'h00, 0, S_WAIT,  6'h3a, 2, 2, 0, 1, 0, 0, 1);
        add(1, 6'h00, 0, S_SERVE, 6'h3a, 2, 2, 0, 1, 0, 0, 1);
        add(0, 6'h00, 0, S_SERVE, 6'h3a, 2, 2, 0, 1, 0, 0, 1);
        add(1, 6'h00, 0, S_PLAY,  6'h3a, 2, 2, 1, 1, 0, 0, 1);
        add(1, 6'h00, 1, S_LOST,  6'h3a, 1, 2, 0, 0, 0, 0, 1);
        add(1, 6'h00, 0, S_WAIT,  6'h3a, 1, 2, 0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 6'h00, 0, S_WAIT, 6'h3a, 1, 2, 0, 1, 0, 0, 1);
        add(1, 6'h00, 0, S_SERVE, 6'h3a, 1, 2, 0, 1, 0, 0, 1);
        add(0, 6'h00, 0, S_SERVE, 6'h3a, 1, 2, 0, 1, 0, 0, 1);
        add(1, 6'h00, 0, S_PLAY,  6'h3a, 1, 2, 1, 1, 0, 0, 1);
        add(1, 6'h00, 1, S_OVER,  6'h3a, 0, 2, 0, 1, 1, 0, 1);
        add(1, 6'h3f, 0, S_OVER,  6'h3a, 0, 2, 0, 1, 1, 0, 1);
        add(0, 6'h00, 0, S_OVER,  6'h3a, 0, 2, 0, 1, 1, 0, 1);
        add(1, 6'h00, 0, S_IDLE,  6'h00, 0, 0, 0, 0, 0, 0, 0);
        add(1, 6'h00, 0, S_SERVE, 6'h3f, 3, 0, 0, 1, 0, 0, 1);
        add(0, 6'h00, 0, S_SERVE, 6'h3f, 3, 0, 0, 1, 0, 0, 1);
        add(1, 6'h00, 0, S_PLAY,  6'h3f, 3, 0, 1, 1, 0, 0, 1);
        add(1, 6'h3e, 0, S_PLAY,  6'h01, 3, 5, 1, 1, 0, 0, 1);
        add(1, 6'h01, 1, S_WON,   6'h00, 3, 6, 0, 1, 0, 1, 1);
        add(0, 6'h3f, 1, S_WON,   6'h00, 3, 6, 0, 1, 0, 1, 1);

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            start_btn = vecs[k].btn;
            brick_hit = vecs[k].hit;
            ball_lost = vecs[k].lost;
            tick();
            $display("vec %0d: btn=%0b hit=%02h lost=%0b -> state=%0d bricks=%02h lives=%0d score=%0d/%0d",
                     k, vecs[k].btn, vecs[k].hit, vecs[k].lost, state, bricks_exist, lives, score, b_score);
            chk($sformatf("v%0d_state", k), int'(state), vecs[k].st);
            chk($sformatf("v%0d_bstart", k), int'(ball_start), int'(vecs[k].bs));
            chk($sformatf("v%0d_over", k), int'(game_over), int'(vecs[k].ov));
            chk($sformatf("v%0d_won", k), int'(game_won), int'(vecs[k].wn));
            if (vecs[k].vals) begin
                chk($sformatf("v%0d_bricks", k), int'(bricks_exist), int'(vecs[k].bricks));
                chk($sformatf("v%0d_lives", k), int'(lives), vecs[k].lv);
                chk($sformatf("v%0d_score", k), int'(score), vecs[k].sc);
                chk($sformatf("v%0d_b_score", k), int'(b_score), sat3(vecs[k].sc));
                chk($sformatf("v%0d_brstn", k), int'(ball_rst_n), int'(vecs[k].rn));
            end
        end

        // From WON: restart, serve, lose a ball, then pull reset in the middle of WAIT.
        brick_hit = '0; ball_lost = 0;
        start_btn = 0; tick();
        start_btn = 1; tick();
        chk("rs_idle", int'(state), S_IDLE);
        tick();
        start_btn = 0; tick();
        start_btn = 1; tick();
        chk("rs_play", int'(state), S_PLAY);
        brick_hit = 6'h10; tick();
        brick_hit = '0; ball_lost = 1; tick();
        chk("rs_lost", int'(state), S_LOST);
        ball_lost = 0; tick(); tick();
        chk("rs_wait", int'(state), S_WAIT);
        chk("rs_wait_score", int'(score), 1);
        #2;
        rst = 1'b0;
        #1;
        $display("async reset mid-WAIT -> state=%0d lives=%0d score=%0d", state, lives, score);
        check_reset_values("async");
        start_btn = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Random play against the reference model.
        model_init();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) start_btn = ~start_btn;
            brick_hit = ($urandom_range(0, 5) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'h00;
            if ($urandom_range(0, 60) == 0) brick_hit = 6'($urandom);
            ball_lost = ($urandom_range(0, 30) == 0);
            @(posedge clk);
            model_step(start_btn, brick_hit, ball_lost);
            #1;
            chk("r_state", int'(state), m_state);
            chk("r_bstart", int'(ball_start), int'(m_state == S_PLAY));
            chk("r_over", int'(game_over), int'(m_state == S_OVER));
            chk("r_won", int'(game_won), int'(m_state == S_WON));
            if (m_state != S_IDLE) begin
                chk("r_bricks", int'(bricks_exist), int'(m_bricks));
                chk("r_lives", int'(lives), m_lives);
                chk("r_score", int'(score), (m_score > 255) ? 255 : m_score);
                chk("r_b_score", int'(b_score), sat3(m_score));
                chk("r_brstn", int'(ball_rst_n), int'(m_state != S_LOST));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
